// File: rtl/store_buffer_if.sv
// Store-buffer bus bundle: MEM-stage store/load requests, memory-side head entry and stall.
interface store_buffer_if #(
   parameter int unsigned AW = 2
);
   logic          st_valid;
   logic [31:0]   st_addr;
   logic [31:0]   st_wdata;
   logic [3:0]    st_byteen;
   logic [31:0]   st_pc;
   logic          ld_valid;
   logic [31:0]   ld_addr;
   logic          mem_ready;
   logic          stall;
   logic [31:0]   m_data_addr;
   logic [31:0]   m_data_wdata;
   logic [3:0]    m_data_byteen;
   logic [31:0]   m_inst_addr;
   logic [AW:0]   count;

   // Pipeline/memory side: drives requests and memory acceptance, observes the buffer.
   modport master (
      output st_valid, st_addr, st_wdata, st_byteen, st_pc,
      output ld_valid, ld_addr, mem_ready,
      input  stall, m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, count
   );

   // Buffer side.
   modport slave (
      input  st_valid, st_addr, st_wdata, st_byteen, st_pc,
      input  ld_valid, ld_addr, mem_ready,
      output stall, m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, count
   );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between the MEM stage and the data memory port. Stores drain in program
// order; a load to any word still pending in the buffer stalls (no forwarding).
module store_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input logic           clk,
   input logic           reset,
   store_buffer_if.slave bus
);
   localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

   logic [29:0]   addrMem   [DEPTH];
   logic [31:0]   wdataMem  [DEPTH];
   logic [3:0]    byteenMem [DEPTH];
   logic [31:0]   pcMem     [DEPTH];

   logic [AW-1:0] wrPtrQ, wrPtrD;
   logic [AW-1:0] rdPtrQ, rdPtrD;
   logic [AW:0]   countQ, countD;

   logic          full;
   logic          empty;
   logic          stReq;
   logic          push;
   logic          pop;
   logic          ldHit;
   logic          unusedAddrBits;

   assign full  = (countQ == FullCount);
   assign empty = (countQ == '0);
   // A store with no byte lanes is not a store at all.
   assign stReq = bus.st_valid & (bus.st_byteen != 4'b0000);
   // Full refuses a push even when a pop frees a slot on the same edge.
   assign push  = stReq & ~full;
   assign pop   = ~empty & bus.mem_ready;

   // Byte offsets are dropped: entries and hazard compares work on word addresses.
   assign unusedAddrBits = ^{bus.st_addr[1:0], bus.ld_addr[1:0]};

   // Next-state for pointers and occupancy.
   always_comb begin
      wrPtrD = wrPtrQ;
      rdPtrD = rdPtrQ;
      countD = countQ;
      if (push) wrPtrD = wrPtrQ + AW'(1);
      if (pop)  rdPtrD = rdPtrQ + AW'(1);
      case ({push, pop})
         2'b10:   countD = countQ + (AW+1)'(1);
         2'b01:   countD = countQ - (AW+1)'(1);
         default: countD = countQ;
      endcase
   end

   // Pointer/occupancy state and entry byte enables; reset discards everything in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtrQ <= '0;
         rdPtrQ <= '0;
         countQ <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            byteenMem[i] <= 4'b0000;
         end
      end else begin
         wrPtrQ <= wrPtrD;
         rdPtrQ <= rdPtrD;
         countQ <= countD;
         if (push) byteenMem[wrPtrQ] <= bus.st_byteen;
      end
   end

   // Entry payload; qualified by count, so it needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         addrMem[wrPtrQ]  <= bus.st_addr[31:2];
         wdataMem[wrPtrQ] <= bus.st_wdata;
         pcMem[wrPtrQ]    <= bus.st_pc;
      end
   end

   // Load hazard: any valid entry (including one popping now) with the same word address.
   always_comb begin
      logic [AW-1:0] offset;
      offset = '0;
      ldHit  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         offset = AW'(i) - rdPtrQ;
         if (({1'b0, offset} < countQ) && (addrMem[i] == bus.ld_addr[31:2])) begin
            ldHit = 1'b1;
         end
      end
      ldHit = ldHit & bus.ld_valid;
   end

   // Head entry presented to memory, forced to zero when the buffer is empty.
   always_comb begin
      bus.m_data_addr   = 32'h0;
      bus.m_data_wdata  = 32'h0;
      bus.m_data_byteen = 4'b0000;
      bus.m_inst_addr   = 32'h0;
      if (!empty) begin
         bus.m_data_addr   = {addrMem[rdPtrQ], 2'b00};
         bus.m_data_wdata  = wdataMem[rdPtrQ];
         bus.m_data_byteen = byteenMem[rdPtrQ];
         bus.m_inst_addr   = pcMem[rdPtrQ];
      end
   end

   assign bus.stall = (stReq & full) | ldHit;
   assign bus.count = countQ;
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed vector table, hand-written corner sequences and random
// traffic, all compared against a queue-based model of the buffer.
module tb_store_buffer;
   logic clk;
   logic reset;
   int   checks;
   int   errors;
   logic modelOn;

   store_buffer_if #(.AW(2)) sbIf ();

   store_buffer #(.DEPTH(4), .AW(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sbIf.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] pc;
   } ent_t;

   ent_t mq[$];

   typedef struct {
      logic        sv;
      logic [31:0] sa;
      logic [31:0] sd;
      logic [3:0]  be;
      logic [31:0] pc;
      logic        lv;
      logic [31:0] la;
      logic        mr;
      logic [31:0] eCount;
      logic        eStall;
      logic [31:0] eAddr;
      logic [31:0] eData;
      logic [3:0]  eBe;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected outputs from the queue: head is the oldest store, stall from full or word match.
   task automatic compareModel();
      logic [31:0] eAddr, eData, ePc;
      logic [3:0]  eBe;
      logic        hit, eStall;
      hit = 1'b0;
      foreach (mq[i]) begin
         if (mq[i].addr[31:2] == sbIf.ld_addr[31:2]) hit = 1'b1;
      end
      eStall = (sbIf.st_valid && sbIf.st_byteen != 4'b0000 && mq.size() == 4)
               || (sbIf.ld_valid && hit);
      if (mq.size() == 0) begin
         eAddr = 32'h0; eData = 32'h0; eBe = 4'b0000; ePc = 32'h0;
      end else begin
         eAddr = {mq[0].addr[31:2], 2'b00};
         eData = mq[0].wdata;
         eBe   = mq[0].be;
         ePc   = mq[0].pc;
      end
      check("model count", 32'(sbIf.count), 32'(mq.size()));
      check("model stall", 32'(sbIf.stall), 32'(eStall));
      check("model addr", sbIf.m_data_addr, eAddr);
      check("model wdata", sbIf.m_data_wdata, eData);
      check("model byteen", 32'(sbIf.m_data_byteen), 32'(eBe));
      check("model pc", sbIf.m_inst_addr, ePc);
   endtask

   // One clock: compare at the falling edge, advance the model, then the rising edge.
   task automatic clockIt();
      logic wasFull;
      @(negedge clk);
      if (modelOn) compareModel();
      if (reset) begin
         mq.delete();
      end else begin
         wasFull = (mq.size() == 4);
         if (mq.size() != 0 && sbIf.mem_ready) void'(mq.pop_front());
         if (sbIf.st_valid && sbIf.st_byteen != 4'b0000 && !wasFull) begin
            mq.push_back('{sbIf.st_addr, sbIf.st_wdata, sbIf.st_byteen, sbIf.st_pc});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic setSt(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic [31:0] pc);
      sbIf.st_valid  = v;
      sbIf.st_addr   = a;
      sbIf.st_wdata  = d;
      sbIf.st_byteen = be;
      sbIf.st_pc     = pc;
   endtask

   task automatic setLd(input logic v, input logic [31:0] a);
      sbIf.ld_valid = v;
      sbIf.ld_addr  = a;
   endtask

   task automatic resetCycle();
      setSt(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
      setLd(1'b0, 32'h0);
      reset = 1'b1;
      clockIt();
      reset = 1'b0;
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      modelOn = 1'b0;
      sbIf.mem_ready = 1'b1;
      setLd(1'b0, 32'h0);

      // Two reset cycles with a store presented: nothing may be enqueued.
      reset = 1'b1;
      setSt(1'b1, 32'h10, 32'h12345678, 4'hF, 32'h100);
      clockIt();
      clockIt();
      reset   = 1'b0;
      modelOn = 1'b1;

      //         sv    sa        sd            be    pc        lv    la      mr
      //         count stall addr      data          be
      vecs[0] = '{1'b0, 32'h0,  32'h0,        4'h0, 32'h0,    1'b0, 32'h0,  1'b1,
                  0,    1'b0, 32'h0,    32'h0,        4'h0};
      vecs[1] = '{1'b1, 32'h10, 32'h12345678, 4'hF, 32'h100,  1'b0, 32'h0,  1'b1,
                  0,    1'b0, 32'h0,    32'h0,        4'h0};
      vecs[2] = '{1'b0, 32'h0,  32'h0,        4'h0, 32'h0,    1'b0, 32'h0,  1'b1,
                  1,    1'b0, 32'h10,   32'h12345678, 4'hF};
      vecs[3] = '{1'b0, 32'h0,  32'h0,        4'h0, 32'h0,    1'b0, 32'h0,  1'b1,
                  0,    1'b0, 32'h0,    32'h0,        4'h0};
      vecs[4] = '{1'b1, 32'h23, 32'hAABBCCDD, 4'hC, 32'h104,  1'b0, 32'h0,  1'b0,
                  0,    1'b0, 32'h0,    32'h0,        4'h0};
      vecs[5] = '{1'b0, 32'h0,  32'h0,        4'h0, 32'h0,    1'b1, 32'h20, 1'b0,
                  1,    1'b1, 32'h20,   32'hAABBCCDD, 4'hC};
      vecs[6] = '{1'b1, 32'h40, 32'h55555555, 4'h0, 32'h108,  1'b0, 32'h0,  1'b0,
                  1,    1'b0, 32'h20,   32'hAABBCCDD, 4'hC};
      vecs[7] = '{1'b0, 32'h0,  32'h0,        4'h0, 32'h0,    1'b0, 32'h0,  1'b1,
                  1,    1'b0, 32'h20,   32'hAABBCCDD, 4'hC};
      vecs[8] = '{1'b0, 32'h0,  32'h0,        4'h0, 32'h0,    1'b0, 32'h0,  1'b1,
                  0,    1'b0, 32'h0,    32'h0,        4'h0};

      foreach (vecs[k]) begin
         setSt(vecs[k].sv, vecs[k].sa, vecs[k].sd, vecs[k].be, vecs[k].pc);
         setLd(vecs[k].lv, vecs[k].la);
         sbIf.mem_ready = vecs[k].mr;
         #1;
         check($sformatf("vec%0d count", k), 32'(sbIf.count), vecs[k].eCount);
         check($sformatf("vec%0d stall", k), 32'(sbIf.stall), 32'(vecs[k].eStall));
         check($sformatf("vec%0d addr", k), sbIf.m_data_addr, vecs[k].eAddr);
         check($sformatf("vec%0d wdata", k), sbIf.m_data_wdata, vecs[k].eData);
         check($sformatf("vec%0d byteen", k), 32'(sbIf.m_data_byteen), 32'(vecs[k].eBe));
         clockIt();
      end

      // Fill to full, fifth store is held until a slot frees.
      resetCycle();
      sbIf.mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         setSt(1'b1, 32'(i * 4), 32'hA0 + 32'(i), 4'h1, 32'h400 + 32'(i * 4));
         #1;
         check("fill stall", 32'(sbIf.stall), 32'h0);
         clockIt();
      end
      setSt(1'b1, 32'h20, 32'hA4, 4'h1, 32'h410);
      for (int i = 0; i < 2; i++) begin
         #1;
         check("full count", 32'(sbIf.count), 32'h4);
         check("full stall", 32'(sbIf.stall), 32'h1);
         check("full head", sbIf.m_data_addr, 32'h0);
         clockIt();
      end
      sbIf.mem_ready = 1'b1;
      #1;
      check("pop-while-full stall", 32'(sbIf.stall), 32'h1);
      check("pop-while-full head", sbIf.m_data_addr, 32'h0);
      clockIt();
      #1;
      check("after refuse count", 32'(sbIf.count), 32'h3);
      check("after refuse stall", 32'(sbIf.stall), 32'h0);
      check("after refuse head", sbIf.m_data_addr, 32'h4);
      clockIt();
      setSt(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
      #1;
      check("drain count", 32'(sbIf.count), 32'h3);
      check("drain head 8", sbIf.m_data_addr, 32'h8);
      clockIt();
      #1;
      check("drain head C", sbIf.m_data_addr, 32'hC);
      clockIt();
      #1;
      check("drain head 20", sbIf.m_data_addr, 32'h20);
      check("drain data 20", sbIf.m_data_wdata, 32'hA4);
      clockIt();
      #1;
      check("drained byteen", 32'(sbIf.m_data_byteen), 32'h0);

      // Load hazard on a pending word, then a different word, then the popping cycle.
      resetCycle();
      sbIf.mem_ready = 1'b0;
      setSt(1'b1, 32'h104, 32'hDEAD0104, 4'hF, 32'h200);
      clockIt();
      setSt(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
      setLd(1'b1, 32'h106);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("ld hit stall", 32'(sbIf.stall), 32'h1);
         clockIt();
      end
      setLd(1'b1, 32'h108);
      #1;
      check("ld miss stall", 32'(sbIf.stall), 32'h0);
      clockIt();
      setLd(1'b1, 32'h106);
      sbIf.mem_ready = 1'b1;
      #1;
      check("ld hit on popping entry", 32'(sbIf.stall), 32'h1);
      clockIt();
      #1;
      check("ld after pop stall", 32'(sbIf.stall), 32'h0);
      check("ld after pop count", 32'(sbIf.count), 32'h0);
      setLd(1'b0, 32'h0);
      clockIt();

      // Steady push+pop at count 2 across the pointer wrap.
      resetCycle();
      sbIf.mem_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         setSt(1'b1, 32'h1000 + 32'(4 * k), 32'h5000 + 32'(k), 4'hF, 32'h600 + 32'(k));
         clockIt();
      end
      sbIf.mem_ready = 1'b1;
      for (int k = 2; k < 7; k++) begin
         setSt(1'b1, 32'h1000 + 32'(4 * k), 32'h5000 + 32'(k), 4'hF, 32'h600 + 32'(k));
         #1;
         check("pushpop count", 32'(sbIf.count), 32'h2);
         check("pushpop head", sbIf.m_data_addr, 32'h1000 + 32'(4 * (k - 2)));
         check("pushpop data", sbIf.m_data_wdata, 32'h5000 + 32'(k - 2));
         clockIt();
      end
      setSt(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
      for (int k = 5; k < 7; k++) begin
         #1;
         check("wrap drain head", sbIf.m_data_addr, 32'h1000 + 32'(4 * k));
         clockIt();
      end
      #1;
      check("wrap drain count", 32'(sbIf.count), 32'h0);

      // Reset with three entries and memory ready: everything is discarded.
      resetCycle();
      sbIf.mem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         setSt(1'b1, 32'h2000 + 32'(4 * k), 32'h7000 + 32'(k), 4'h3, 32'h700);
         clockIt();
      end
      setSt(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
      sbIf.mem_ready = 1'b1;
      reset = 1'b1;
      #1;
      check("pre-reset count", 32'(sbIf.count), 32'h3);
      clockIt();
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("post-reset count", 32'(sbIf.count), 32'h0);
         check("post-reset byteen", 32'(sbIf.m_data_byteen), 32'h0);
         check("post-reset addr", sbIf.m_data_addr, 32'h0);
         clockIt();
      end

      // Random traffic on a small address window so hazards and full cycles are common.
      for (int n = 0; n < 2000; n++) begin
         reset = ($urandom_range(63) == 0);
         setSt(1'($urandom_range(1)),
               32'h300 + (32'($urandom_range(15)) << 2) + 32'($urandom_range(3)),
               $urandom, 4'($urandom_range(15)), $urandom);
         setLd(1'($urandom_range(1)),
               32'h300 + (32'($urandom_range(15)) << 2) + 32'($urandom_range(3)));
         sbIf.mem_ready = ($urandom_range(2) == 0);
         clockIt();
      end
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
